fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/HOLD sequencer with redirect kill and a one-entry stall buffer.
// Optional macro FETCH_STAT_EN adds a completed-fetch counter on fetch_count_o.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic        jump_i,
   input  logic [31:0] branch_target_i,
   input  logic [31:0] jump_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] addedPC_o,
   output logic [31:0] inst_o,
   output logic        valid_o,
   output logic [31:0] fetch_count_o
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] tgt_q;
   logic        kill_q;
   logic [31:0] buf_q;
   logic        redirect;
   logic [31:0] target;
   logic        accept;

   assign redirect    = jump_i | branch_i;
   assign target      = jump_i ? jump_target_i : branch_target_i;
   assign accept      = (state_q == REQ) && imem_ack_i && !kill_q && !redirect;
   assign imem_req_o  = (state_q == REQ);
   assign imem_addr_o = pc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ:  if (accept && stall_i) state_d = HOLD;
         HOLD: if (redirect || !stall_i) state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   // pc_q always holds the address of the outstanding (or next) request;
   // after a buffered fetch it already points at addr+4, which is the buffered addedPC.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q      <= RESET_PC;
         kill_q    <= 1'b0;
         addedPC_o <= '0;
         inst_o    <= '0;
         valid_o   <= 1'b0;
      end else if (redirect) begin
         addedPC_o <= '0;
         inst_o    <= '0;
         valid_o   <= 1'b0;
         if (state_q == REQ && !imem_ack_i) begin
            kill_q <= 1'b1;
            tgt_q  <= target;
         end else begin
            kill_q <= 1'b0;
            pc_q   <= target;
         end
      end else begin
         case (state_q)
            REQ: begin
               if (imem_ack_i && kill_q) begin
                  kill_q <= 1'b0;
                  pc_q   <= tgt_q;
                  if (!stall_i) valid_o <= 1'b0;
               end else if (imem_ack_i) begin
                  pc_q <= pc_q + 32'd4;
                  if (!stall_i) begin
                     inst_o    <= imem_data_i;
                     addedPC_o <= pc_q + 32'd4;
                     valid_o   <= 1'b1;
                  end else begin
                     buf_q <= imem_data_i;
                  end
               end else if (!stall_i) begin
                  valid_o <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  inst_o    <= buf_q;
                  addedPC_o <= pc_q;
                  valid_o   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_STAT_EN
   logic [31:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)       count_q <= '0;
      else if (accept) count_q <= count_q + 32'd1;
   end

   assign fetch_count_o = count_q;
`else
   assign fetch_count_o = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction-level reference model checked every cycle,
// plus literal expectations for the reset, streaming, wait, stall, kill, priority and wrap cases.
module tb_fetch_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        br = 1'b0;
   logic        jp = 1'b0;
   logic [31:0] btgt = '0;
   logic [31:0] jtgt = '0;
   logic        ack = 1'b0;
   logic [31:0] data;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] added_pc;
   logic [31:0] inst;
   logic        valid;
   logic [31:0] fetch_count;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   // reference model: phase 0 = waiting to start, 1 = requesting, 2 = holding a buffered word
   int          m_phase = 0;
   logic [31:0] m_addr = RPC;
   logic [31:0] m_pending = '0;
   bit          m_discard = 1'b0;
   logic [31:0] m_buf = '0;
   logic [31:0] m_inst = '0;
   logic [31:0] m_added = '0;
   logic        m_valid = 1'b0;
   logic [31:0] m_cnt = '0;

   // memory returns the address as the word, garbage when not acking
   assign data = ack ? imem_addr : 32'hDEAD_BEEF;

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_i(br), .jump_i(jp),
      .branch_target_i(btgt), .jump_target_i(jtgt),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_ack_i(ack), .imem_data_i(data),
      .addedPC_o(added_pc), .inst_o(inst), .valid_o(valid),
      .fetch_count_o(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      bit redir;
      if (rst) begin
         m_phase = 0; m_addr = RPC; m_discard = 1'b0;
         m_inst = '0; m_added = '0; m_valid = 1'b0; m_cnt = '0;
         return;
      end
      redir = br | jp;
      tgt   = jp ? jtgt : btgt;
      if (redir) begin
         m_inst = '0; m_added = '0; m_valid = 1'b0;
         if (m_phase == 1 && !ack) begin
            m_discard = 1'b1;
            m_pending = tgt;
         end else begin
            m_discard = 1'b0;
            m_addr = tgt;
            m_phase = 1;
         end
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 2) begin
         if (!stall) begin
            m_inst = m_buf; m_added = m_addr; m_valid = 1'b1; m_phase = 1;
         end
      end else if (ack && m_discard) begin
         m_discard = 1'b0;
         m_addr = m_pending;
         if (!stall) m_valid = 1'b0;
      end else if (ack) begin
`ifdef FETCH_STAT_EN
         m_cnt = m_cnt + 32'd1;
`endif
         if (!stall) begin
            m_inst = m_addr; m_added = m_addr + 32'd4; m_valid = 1'b1;
         end else begin
            m_buf = m_addr; m_phase = 2;
         end
         m_addr = m_addr + 32'd4;
      end else if (!stall) begin
         m_valid = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
         if (m_phase == 1) chk("m_addr", imem_addr, m_addr);
         chk("m_valid", {31'd0, valid}, {31'd0, m_valid});
         chk("m_inst", inst, m_inst);
         chk("m_added", added_pc, m_added);
         chk("m_count", fetch_count, m_cnt);
      end
   end

   task automatic step(input bit r, input bit a, input bit s, input bit b, input bit j,
                       input logic [31:0] bt, input logic [31:0] jt);
      rst = r; ack = a; stall = s; br = b; jp = j; btgt = bt; jtgt = jt;
      @(posedge clk);
      model_step();
      #1;
      if (r) chk_en = 1'b1;
   endtask

   task automatic go(input bit a, input bit s);
      step(1'b0, a, s, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic jmp(input bit a, input bit s, input logic [31:0] t);
      step(1'b0, a, s, 1'b0, 1'b1, 32'h0, t);
   endtask

   task automatic brn(input bit a, input bit s, input logic [31:0] t);
      step(1'b0, a, s, 1'b1, 1'b0, t, 32'h0);
   endtask

   initial begin
      logic [31:0] exp_cnt;

      // reset
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_added", added_pc, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);

      // streaming with zero-wait memory
      go(1'b0, 1'b0);
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h100);
      go(1'b1, 1'b0);
      chk("s1_inst", inst, 32'h100);
      chk("s1_added", added_pc, 32'h104);
      chk("s1_addr", imem_addr, 32'h104);
      go(1'b1, 1'b0);
      chk("s2_inst", inst, 32'h104);
      chk("s2_added", added_pc, 32'h108);
      chk("s2_addr", imem_addr, 32'h108);
      go(1'b1, 1'b0);

      // delayed ack
      jmp(1'b1, 1'b0, 32'h200);
      chk("w_addr0", imem_addr, 32'h200);
      for (int i = 0; i < 3; i++) begin
         go(1'b0, 1'b0);
         chk("w_addr", imem_addr, 32'h200);
         chk("w_valid", {31'd0, valid}, 32'd0);
      end
      go(1'b1, 1'b0);
      chk("w_inst", inst, 32'h200);
      chk("w_added", added_pc, 32'h204);
      chk("w_vld", {31'd0, valid}, 32'd1);

      // stall on ack into the buffer
      jmp(1'b1, 1'b0, 32'h2FC);
      go(1'b1, 1'b0);
      go(1'b1, 1'b1);
      chk("st_req", {31'd0, imem_req}, 32'd0);
      chk("st_inst", inst, 32'h2FC);
      go(1'b0, 1'b1);
      chk("st_req2", {31'd0, imem_req}, 32'd0);
      chk("st_added", added_pc, 32'h300);
      go(1'b0, 1'b0);
      chk("st_inst_rel", inst, 32'h300);
      chk("st_added_rel", added_pc, 32'h304);
      chk("st_next_addr", imem_addr, 32'h304);

      // branch during an unacked request
      jmp(1'b1, 1'b0, 32'h500);
      brn(1'b0, 1'b0, 32'h400);
      chk("k_addr", imem_addr, 32'h500);
      go(1'b0, 1'b0);
      go(1'b1, 1'b0);
      chk("k_valid", {31'd0, valid}, 32'd0);
      chk("k_next", imem_addr, 32'h400);
      go(1'b1, 1'b0);
      chk("k_inst", inst, 32'h400);

      // jump beats branch, overrides stall
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h900, 32'h800);
      chk("p_valid", {31'd0, valid}, 32'd0);
      chk("p_inst", inst, 32'd0);
      chk("p_addr", imem_addr, 32'h800);
      go(1'b1, 1'b0);

      // redirect while holding a buffered word
      go(1'b1, 1'b1);
      jmp(1'b0, 1'b1, 32'hA00);
      chk("h_addr", imem_addr, 32'hA00);
      go(1'b1, 1'b0);
      chk("h_inst", inst, 32'hA00);

      // PC wrap
      jmp(1'b1, 1'b0, 32'hFFFF_FFF8);
      go(1'b1, 1'b0);
      go(1'b1, 1'b0);
      chk("wrap_added", added_pc, 32'h0);
      chk("wrap_addr", imem_addr, 32'h0);

      // reset mid-request with acks during and right after reset
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("ra_valid", {31'd0, valid}, 32'd0);
      chk("ra_addr", imem_addr, RPC);

      // five accepted fetches and one killed
      for (int i = 0; i < 5; i++) go(1'b1, 1'b0);
      brn(1'b0, 1'b0, 32'h600);
      go(1'b1, 1'b0);
`ifdef FETCH_STAT_EN
      exp_cnt = 32'd5;
`else
      exp_cnt = 32'd0;
`endif
      chk("cnt5", fetch_count, exp_cnt);
      chk("cnt_addr", imem_addr, 32'h600);

      // mixed traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 97) == 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
              ($urandom % 12) == 0, ($urandom % 14) == 0,
              {$urandom_range(0, 255), 2'b00} << 4, {$urandom_range(0, 255), 2'b00} << 8);
      end

      go(1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
